// File: rtl/spk_out.sv
// Transmit side of the node flit link: arbitrates soma spikes and config flits into a FIFO
// and emits them toward the router under credit-based flow control.
module spk_out #(
  parameter int unsigned B           = 4,
  parameter int unsigned FW          = 59,
  parameter int unsigned FTW         = 3,
  parameter int unsigned SW          = 24,
  parameter int unsigned CREDIT_INIT = 16
) (
  input  logic            clk_spk_out,
  input  logic            rst_n,
  input  logic            soma_spk_out_vld,
  input  logic [FTW-1:0]  soma_spk_out_type,
  input  logic [SW-1:0]   soma_spk_out_data,
  output logic            spk_out_soma_busy,
  input  logic            config_spk_out_vld,
  input  logic [FW-1:0]   config_spk_out_data,
  output logic            spk_out_config_busy,
  output logic [FW-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic            credit_in,
  output logic            spk_out_credit_err,
  output logic            spk_out_idle
);

  localparam int unsigned DEPTH = 1 << B;

  typedef enum logic [FTW-1:0] {
    FT_SPIKE    = FTW'(0),
    FT_DATA     = FTW'(1),
    FT_DATA_END = FTW'(2),
    FT_WRITE    = FTW'(6),
    FT_READ     = FTW'(7)
  } flit_type_e;

  logic [FW-1:0]  mem [DEPTH];
  logic [B-1:0]   wr_ptr, rd_ptr;
  logic [B:0]     fifo_cnt;
  logic [B:0]     credit_cnt;
  logic           full, empty;
  logic           push_cfg, push_soma, push, pop;
  logic [FTW-1:0] soma_type_fixed;
  logic [FW-1:0]  soma_flit, push_flit;
  logic           credit_at_max;

  assign full  = (fifo_cnt == (B+1)'(DEPTH));
  assign empty = (fifo_cnt == '0);

  assign spk_out_config_busy = full;
  assign spk_out_soma_busy   = full || config_spk_out_vld;

  assign push_cfg  = config_spk_out_vld && !full;
  assign push_soma = soma_spk_out_vld && !spk_out_soma_busy;
  assign push      = push_cfg || push_soma;
  assign pop       = !empty && (credit_cnt != '0);

  // Soma may only emit spike-class types; anything else is sent as a plain SPIKE.
  always_comb begin
    soma_type_fixed = FT_SPIKE;
    case (soma_spk_out_type)
      FT_SPIKE, FT_DATA, FT_DATA_END: soma_type_fixed = soma_spk_out_type;
      default:                        soma_type_fixed = FT_SPIKE;
    endcase
  end

  assign soma_flit = {soma_type_fixed, {(FW-FTW-SW){1'b0}}, soma_spk_out_data};
  assign push_flit = push_cfg ? config_spk_out_data : soma_flit;

  always_ff @(posedge clk_spk_out) begin
    if (push) mem[wr_ptr] <= push_flit;
  end

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= pop;
      if (pop) flit_out <= mem[rd_ptr];
    end
  end

  assign credit_at_max = (credit_cnt == (B+1)'(CREDIT_INIT));

  // A credit arriving while already full-up saturates and flags the error instead of wrapping.
  always_ff @(posedge clk_spk_out or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt         <= (B+1)'(CREDIT_INIT);
      spk_out_credit_err <= 1'b0;
    end else begin
      case ({credit_in, pop})
        2'b01: credit_cnt <= credit_cnt - 1'b1;
        2'b10: begin
          if (credit_at_max) spk_out_credit_err <= 1'b1;
          else               credit_cnt <= credit_cnt + 1'b1;
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign spk_out_idle = empty && !flit_out_wr;

endmodule

// File: tb/tb_spk_out.sv
// Scoreboard bench for spk_out: a reference FIFO/credit model predicts busy, flit_out and flags.
module tb_spk_out;

  logic        clk_spk_out;
  logic        rst_n;
  logic        soma_spk_out_vld;
  logic [2:0]  soma_spk_out_type;
  logic [23:0] soma_spk_out_data;
  logic        spk_out_soma_busy;
  logic        config_spk_out_vld;
  logic [58:0] config_spk_out_data;
  logic        spk_out_config_busy;
  logic [58:0] flit_out;
  logic        flit_out_wr;
  logic        credit_in;
  logic        spk_out_credit_err;
  logic        spk_out_idle;

  spk_out #(.B(4), .FW(59), .FTW(3), .SW(24), .CREDIT_INIT(16)) dut (
    .clk_spk_out         (clk_spk_out),
    .rst_n               (rst_n),
    .soma_spk_out_vld    (soma_spk_out_vld),
    .soma_spk_out_type   (soma_spk_out_type),
    .soma_spk_out_data   (soma_spk_out_data),
    .spk_out_soma_busy   (spk_out_soma_busy),
    .config_spk_out_vld  (config_spk_out_vld),
    .config_spk_out_data (config_spk_out_data),
    .spk_out_config_busy (spk_out_config_busy),
    .flit_out            (flit_out),
    .flit_out_wr         (flit_out_wr),
    .credit_in           (credit_in),
    .spk_out_credit_err  (spk_out_credit_err),
    .spk_out_idle        (spk_out_idle)
  );

  initial clk_spk_out = 1'b0;
  always #5 clk_spk_out = ~clk_spk_out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [58:0] fq [$];
  int unsigned m_cred;
  logic [58:0] m_flit;
  logic        m_wr;
  logic        m_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [58:0] mk_flit(input logic [2:0] t, input logic [23:0] d);
    logic [2:0] tt;
    tt = (t > 3'd2) ? 3'b000 : t;
    return {tt, 32'h0, d};
  endfunction

  task automatic model_reset();
    fq.delete();
    m_cred = 16;
    m_flit = '0;
    m_wr   = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_spk_out);
    soma_spk_out_vld = 0; config_spk_out_vld = 0; credit_in = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wr",   64'(flit_out_wr),        64'(0));
    check("rst_idle", 64'(spk_out_idle),       64'(1));
    check("rst_err",  64'(spk_out_credit_err), 64'(0));
    check("rst_flit", 64'(flit_out),           64'(0));
    @(negedge clk_spk_out);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic sv, input logic [2:0] st, input logic [23:0] sd,
                       input logic cv, input logic [58:0] cd, input logic cr,
                       output logic s_acc, output logic wr_seen);
    logic full, c_acc, pop;
    @(negedge clk_spk_out);
    soma_spk_out_vld   = sv;
    soma_spk_out_type  = st;
    soma_spk_out_data  = sd;
    config_spk_out_vld = cv;
    config_spk_out_data = cd;
    credit_in          = cr;
    #1;
    full = (fq.size() == 16);
    if (cv) check("cfg_busy",  64'(spk_out_config_busy), 64'(full));
    if (sv) check("soma_busy", 64'(spk_out_soma_busy),   64'(full || cv));
    c_acc = cv && !full;
    s_acc = sv && !(full || cv);
    pop   = (fq.size() != 0) && (m_cred != 0);
    @(posedge clk_spk_out);
    if (pop) m_flit = fq.pop_front();
    m_wr = pop;
    if (c_acc)      fq.push_back(cd);
    else if (s_acc) fq.push_back(mk_flit(st, sd));
    if (pop && !cr)      m_cred--;
    else if (cr && !pop) begin
      if (m_cred == 16) m_err = 1'b1;
      else              m_cred++;
    end
    #1;
    check("wr",   64'(flit_out_wr),        64'(m_wr));
    check("flit", 64'(flit_out),           64'(m_flit));
    check("idle", 64'(spk_out_idle),       64'(fq.size() == 0 && !m_wr));
    check("err",  64'(spk_out_credit_err), 64'(m_err));
    wr_seen = flit_out_wr;
  endtask

  task automatic idle_cycles(input int unsigned n, input logic cr, output int unsigned pulses);
    logic a, w;
    pulses = 0;
    for (int unsigned i = 0; i < n; i++) begin
      cycle(1'b0, 3'b000, 24'h0, 1'b0, 59'h0, cr, a, w);
      if (w) pulses++;
    end
  endtask

  initial begin
    logic a, w;
    int unsigned pulses, seq;
    rst_n = 1'b0;
    soma_spk_out_vld = 0; soma_spk_out_type = 0; soma_spk_out_data = 0;
    config_spk_out_vld = 0; config_spk_out_data = 0; credit_in = 0;
    model_reset();
    repeat (2) @(posedge clk_spk_out);
    do_reset();

    // 1: single spike, 2-cycle latency
    cycle(1'b1, 3'b000, 24'h0A0B0C, 1'b0, 59'h0, 1'b0, a, w);
    check("t1_acc", 64'(a), 64'(1));
    check("t1_early", 64'(w), 64'(0));
    cycle(1'b0, 3'b000, 24'h0, 1'b0, 59'h0, 1'b0, a, w);
    check("t1_wr", 64'(w), 64'(1));
    check("t1_flit", 64'(flit_out), 64'({3'b000, 32'h0, 24'h0A0B0C}));
    idle_cycles(2, 1'b0, pulses);
    check("t1_idle", 64'(spk_out_idle), 64'(1));

    // 2: simultaneous requests, config wins; soma resubmits; bad soma type forced to SPIKE
    cycle(1'b1, 3'b101, 24'h123456, 1'b1, {3'b110, 56'hCAFE_0000_BEEF01}, 1'b0, a, w);
    check("t2_soma_refused", 64'(a), 64'(0));
    cycle(1'b1, 3'b101, 24'h123456, 1'b0, 59'h0, 1'b0, a, w);
    check("t2_resubmit", 64'(a), 64'(1));
    cycle(1'b1, 3'b010, 24'hABCDEF, 1'b1, {3'b111, 56'h00_1111_2222_3333}, 1'b0, a, w);
    cycle(1'b1, 3'b010, 24'hABCDEF, 1'b0, 59'h0, 1'b0, a, w);
    idle_cycles(4, 1'b0, pulses);

    // 3: no credit return; fill downstream and FIFO, then release 4 credits
    do_reset();
    seq = 0; pulses = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      cycle(1'b1, 3'b001, 24'(seq), 1'b0, 59'h0, 1'b0, a, w);
      if (a) seq++;
      if (w) pulses++;
    end
    check("t3_pulses", 64'(pulses), 64'(16));
    check("t3_accepted", 64'(seq), 64'(32));
    check("t3_full_busy", 64'(spk_out_soma_busy), 64'(1));
    idle_cycles(4, 1'b1, pulses);
    begin
      int unsigned p2;
      idle_cycles(6, 1'b0, p2);
      check("t3_released", 64'(pulses + p2), 64'(4));
    end

    // 4: credit returned with every pop keeps 1 flit/cycle
    do_reset();
    pulses = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      logic pred;
      pred = (fq.size() != 0) && (m_cred != 0);
      cycle(1'b1, 3'b000, 24'(i + 24'h100), 1'b0, 59'h0, pred, a, w);
      if (w) pulses++;
    end
    check("t4_rate", 64'(pulses), 64'(49));
    idle_cycles(3, 1'b0, pulses);

    // 5: spurious credit at full count -> sticky error; count stays at 16
    do_reset();
    idle_cycles(1, 1'b1, pulses);
    check("t5_err", 64'(spk_out_credit_err), 64'(1));
    idle_cycles(3, 1'b0, pulses);
    check("t5_sticky", 64'(spk_out_credit_err), 64'(1));
    seq = 0; pulses = 0;
    for (int unsigned i = 0; i < 24; i++) begin
      cycle(1'b1, 3'b000, 24'(seq + 24'h500), 1'b0, 59'h0, 1'b0, a, w);
      if (a) seq++;
      if (w) pulses++;
    end
    check("t5_credits16", 64'(pulses), 64'(16));

    // 6: reset with flits queued; nothing stale afterwards
    do_reset();
    for (int unsigned i = 0; i < 5; i++)
      cycle(1'b1, 3'b000, 24'(24'h900 + i), 1'b0, 59'h0, 1'b0, a, w);
    do_reset();
    idle_cycles(10, 1'b0, pulses);
    check("t6_no_stale", 64'(pulses), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
